gsu_icache: RTL

//  GSU instruction cache with a configurable line size and line count. Serves GSU opcode fetches from on-chip RAM.
//  On a miss it fills a whole line from the ROM bus. Fetches outside the cache window go directly to ROM, uncached.
//  The SNES side can also load code into the cache through the $3100-$32FF window.

---
 rtl/gsu_icache.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gsu_icache.sv
// rtl/gsu_icache.sv - GSU instruction cache: line fill from ROM, uncached bypass, SNES preload port
// Single write port shared by SNES writes (priority) and line fills; fetch and SNES reads are registered.
module gsu_icache #(
  parameter int LINE_BYTES = 16,
  parameter int LINES      = 32
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] fetch_pc,
  input  logic [7:0]  fetch_pbr,
  output logic        fetch_rdy,
  output logic [7:0]  fetch_data,
  input  logic [15:0] cbr,
  input  logic        flush,
  input  logic        snes_we,
  input  logic [9:0]  snes_addr,
  input  logic [7:0]  snes_di,
  output logic [7:0]  snes_do,
  output logic [23:0] ROM_BUS_ADDR,
  output logic        ROM_BUS_RRQ,
  input  logic        ROM_BUS_RDY,
  input  logic [7:0]  ROM_BUS_DI,
  output logic        fill_busy
);

  localparam int OB = $clog2(LINE_BYTES);
  localparam int AW = $clog2(LINE_BYTES * LINES);
  localparam int LW = AW - OB;
  localparam logic [16:0] WIN = 17'(LINE_BYTES * LINES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FILL_REQ, S_FILL_WAIT, S_UNC_REQ, S_UNC_WAIT, S_DRAIN
  } state_t;

  state_t             state_q;
  logic [15:0]        pc_q;
  logic [7:0]         pbr_q;
  logic [LW-1:0]      line_q;
  logic [OB-1:0]      k_q;
  logic [7:0]         hold_q;
  logic               pend_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   valid_d;
  logic               fetch_rdy_q;
  logic [7:0]         fetch_data_q;
  logic               rrq_q;
  logic [23:0]        addr_q;
  logic [7:0]         snes_do_q;
  logic [7:0]         mem [LINE_BYTES*LINES];

  logic [15:0]        off;
  logic               in_win;
  logic [LW-1:0]      off_line;
  logic [OB-1:0]      k_nxt;
  logic               fill_wr;
  logic               fill_last;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [7:0]         mem_wdata;
  logic               unused_bits;

  assign off         = pc_q - {cbr[15:OB], {OB{1'b0}}};
  assign in_win      = {1'b0, off} < WIN;
  assign off_line    = off[AW-1:OB];
  assign k_nxt       = k_q + OB'(1);
  assign unused_bits = ^{cbr, snes_addr};

  // A fill byte colliding with an SNES write is parked in hold_q and written on a later free cycle.
  always_comb begin
    fill_wr   = (state_q == S_FILL_WAIT) && !flush && !snes_we && (pend_q || ROM_BUS_RDY);
    fill_last = fill_wr && (&k_q);
    mem_we    = snes_we || fill_wr;
    mem_waddr = snes_we ? snes_addr[AW-1:0] : {line_q, k_q};
    mem_wdata = snes_we ? snes_di : (pend_q ? hold_q : ROM_BUS_DI);
    valid_d   = valid_q;
    if (snes_we && (&snes_addr[OB-1:0])) valid_d[snes_addr[AW-1:OB]] = 1'b1;
    if (fill_last) valid_d[line_q] = 1'b1;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clkin) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clkin) begin
    if (reset) snes_do_q <= 8'h00;
    else       snes_do_q <= mem[snes_addr[AW-1:0]];
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      pbr_q        <= '0;
      line_q       <= '0;
      k_q          <= '0;
      hold_q       <= '0;
      pend_q       <= 1'b0;
      valid_q      <= '0;
      fetch_rdy_q  <= 1'b0;
      fetch_data_q <= '0;
      rrq_q        <= 1'b0;
      addr_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      fetch_rdy_q <= 1'b0;
      rrq_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_req) begin
            pc_q    <= fetch_pc;
            pbr_q   <= fetch_pbr;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          line_q <= off_line;
          if (!in_win) begin
            rrq_q   <= 1'b1;
            addr_q  <= {pbr_q, pc_q};
            state_q <= S_UNC_REQ;
          end else if (valid_q[off_line] && !flush) begin
            fetch_rdy_q  <= 1'b1;
            fetch_data_q <= mem[off[AW-1:0]];
            state_q      <= S_IDLE;
          end else begin
            k_q     <= '0;
            rrq_q   <= 1'b1;
            addr_q  <= {pbr_q, pc_q[15:OB], {OB{1'b0}}};
            state_q <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: state_q <= flush ? S_DRAIN : S_FILL_WAIT;
        S_FILL_WAIT: begin
          if (flush) begin
            pend_q  <= 1'b0;
            state_q <= (pend_q || ROM_BUS_RDY) ? S_IDLE : S_DRAIN;
          end else if (fill_wr) begin
            pend_q <= 1'b0;
            if (&k_q) begin
              state_q <= S_LOOKUP;
            end else begin
              k_q     <= k_nxt;
              rrq_q   <= 1'b1;
              addr_q  <= {pbr_q, pc_q[15:OB], k_nxt};
              state_q <= S_FILL_REQ;
            end
          end else if (ROM_BUS_RDY) begin
            hold_q <= ROM_BUS_DI;
            pend_q <= 1'b1;
          end
        end
        S_UNC_REQ: state_q <= flush ? S_DRAIN : S_UNC_WAIT;
        S_UNC_WAIT: begin
          if (ROM_BUS_RDY) begin
            if (!flush) begin
              fetch_rdy_q  <= 1'b1;
              fetch_data_q <= ROM_BUS_DI;
            end
            state_q <= S_IDLE;
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ROM_BUS_RDY) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fetch_rdy    = fetch_rdy_q;
  assign fetch_data   = fetch_data_q;
  assign snes_do      = snes_do_q;
  assign ROM_BUS_RRQ  = rrq_q;
  assign ROM_BUS_ADDR = addr_q;
  assign fill_busy    = (state_q != S_IDLE) && (state_q != S_LOOKUP);

endmodule
